// File: rtl/stall_unit_pkg.sv
// Shared core definitions for the hazard controller: FSM states, register-zero,
// bubble encoding and the per-stage enable/flush bundle.
package stall_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO      = 5'd0;
    // addi x0, x0, 0 with register write suppressed
    localparam logic [31:0] BUBBLE_INSTR  = 32'h0000_0013;
    localparam logic        BUBBLE_REGWRT = 1'b0;

    // Wait counter width, sized to hold the largest WAIT_TIMEOUT (255)
    localparam int WAIT_W = 8;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic de_en;
        logic em_en;
        logic mw_en;
        logic fd_flush;
        logic de_flush;
        logic mw_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RESET     = pipe_ctrl_t'(8'b0000_0111);
    localparam pipe_ctrl_t CTRL_FAULT     = pipe_ctrl_t'(8'b0000_0000);
    localparam pipe_ctrl_t CTRL_MEM_WAIT  = pipe_ctrl_t'(8'b0000_1001);
    localparam pipe_ctrl_t CTRL_BRANCH    = pipe_ctrl_t'(8'b1111_1110);
    localparam pipe_ctrl_t CTRL_LOAD_USE  = pipe_ctrl_t'(8'b0011_1010);
    localparam pipe_ctrl_t CTRL_NONE      = pipe_ctrl_t'(8'b1111_1000);

endpackage

// File: rtl/stall_unit_hazard_detect.sv
// Combinational load-use comparator between the FD consumer and a load in DE.
module hazard_detect
    import stall_unit_pkg::*;
(
    input  logic [4:0] fd_rs1,
    input  logic [4:0] fd_rs2,
    input  logic       fd_use_rs1,
    input  logic       fd_use_rs2,
    input  logic [4:0] de_rd,
    input  logic       de_regwrt,
    input  logic       de_m2r,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = fd_use_rs1 && (fd_rs1 == de_rd);
    assign rs2_hit  = fd_use_rs2 && (fd_rs2 == de_rd);
    // x0 is never a real dependency, so a load targeting it cannot stall
    assign load_use = de_regwrt && de_m2r && (de_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/stall_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory wait
// states with timeout supervision, and saturating hazard statistics.
module stall_unit
    import stall_unit_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       fd_rs1,
    input  logic [4:0]       fd_rs2,
    input  logic             fd_use_rs1,
    input  logic             fd_use_rs2,
    input  logic [4:0]       de_rd,
    input  logic             de_regwrt,
    input  logic             de_m2r,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             mw_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg;
    logic               mem_err_reg;

    logic               load_use;
    logic               mem_wait;
    logic               branch_act;
    logic               stall_inc;
    pipe_ctrl_t         ctrl;

    hazard_detect u_hazard_detect (
        .fd_rs1     (fd_rs1),
        .fd_rs2     (fd_rs2),
        .fd_use_rs1 (fd_use_rs1),
        .fd_use_rs2 (fd_use_rs2),
        .de_rd      (de_rd),
        .de_regwrt  (de_regwrt),
        .de_m2r     (de_m2r),
        .load_use   (load_use)
    );

    assign mem_wait = dmem_req && !dmem_ready;

    // Reset is folded in so the bubble pattern appears the instant rst_n drops
    always_comb begin
        ctrl       = CTRL_NONE;
        branch_act = 1'b0;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else if (state_reg == FAULT) begin
            ctrl = CTRL_FAULT;
        end else if (mem_wait) begin
            ctrl = CTRL_MEM_WAIT;
        end else if (branch_taken) begin
            ctrl       = CTRL_BRANCH;
            branch_act = 1'b1;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                wait_cnt_next = '0;
                if (mem_wait) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_W'(WAIT_TIMEOUT)) begin
                    state_next = FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    assign stall_inc = !ctrl.pc_en && (state_reg != FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            mem_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_next == FAULT) begin
                mem_err_reg <= 1'b1;
            end
            if (stall_inc && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (branch_act && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign pc_en     = ctrl.pc_en;
    assign fd_en     = ctrl.fd_en;
    assign de_en     = ctrl.de_en;
    assign em_en     = ctrl.em_en;
    assign mw_en     = ctrl.mw_en;
    assign fd_flush  = ctrl.fd_flush;
    assign de_flush  = ctrl.de_flush;
    assign mw_flush  = ctrl.mw_flush;
    assign mem_err   = mem_err_reg;
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_stall_unit.sv
// Self-checking bench for stall_unit: cycle scoreboard against a small reference
// model plus directed checks of the load-use, branch, wait, timeout and reset cases.
module tb_stall_unit;

    localparam int TO  = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    fd_rs1 = '0, fd_rs2 = '0, de_rd = '0;
    logic          fd_use_rs1 = 1'b0, fd_use_rs2 = 1'b0;
    logic          de_regwrt = 1'b0, de_m2r = 1'b0;
    logic          branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic          pc_en, fd_en, de_en, em_en, mw_en;
    logic          fd_flush, de_flush, mw_flush, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    stall_unit #(.WAIT_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fd_rs1       (fd_rs1),
        .fd_rs2       (fd_rs2),
        .fd_use_rs1   (fd_use_rs1),
        .fd_use_rs2   (fd_use_rs2),
        .de_rd        (de_rd),
        .de_regwrt    (de_regwrt),
        .de_m2r       (de_m2r),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .de_en        (de_en),
        .em_en        (em_en),
        .mw_en        (mw_en),
        .fd_flush     (fd_flush),
        .de_flush     (de_flush),
        .mw_flush     (mw_flush),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    // Control bit order: pc fd de em mw | fd_flush de_flush mw_flush
    localparam logic [7:0] P_RESET = 8'b0000_0111;
    localparam logic [7:0] P_FAULT = 8'b0000_0000;
    localparam logic [7:0] P_MWAIT = 8'b0000_1001;
    localparam logic [7:0] P_BRAN  = 8'b1111_1110;
    localparam logic [7:0] P_LU    = 8'b0011_1010;
    localparam logic [7:0] P_NONE  = 8'b1111_1000;

    typedef struct packed {
        logic [7:0]    ctrl;
        logic          err;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: 0 = run, 1 = waiting, 2 = fault
    int   m_state = 0;
    int   m_wait  = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    int   m_err   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_ctrl();
        return {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush};
    endfunction

    function automatic logic model_lu();
        logic hit1, hit2;
        hit1 = fd_use_rs1 && (fd_rs1 == de_rd);
        hit2 = fd_use_rs2 && (fd_rs2 == de_rd);
        return de_regwrt && de_m2r && (de_rd != 5'd0) && (hit1 || hit2);
    endfunction

    function automatic logic [7:0] model_ctrl();
        if (m_state == 2)                     return P_FAULT;
        if (dmem_req && !dmem_ready)          return P_MWAIT;
        if (branch_taken)                     return P_BRAN;
        if (model_lu())                       return P_LU;
        return P_NONE;
    endfunction

    task automatic set_idle();
        fd_rs1 = '0; fd_rs2 = '0; de_rd = '0;
        fd_use_rs1 = 1'b0; fd_use_rs2 = 1'b0;
        de_regwrt = 1'b0; de_m2r = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_lu_rs1(input logic [4:0] rd);
        de_rd = rd; de_regwrt = 1'b1; de_m2r = 1'b1;
        fd_rs1 = 5'd5; fd_use_rs1 = 1'b1;
    endtask

    // Called just after a rising edge: drive, score at the falling edge, advance model.
    task automatic cycle(input string tag);
        exp_t       e, got;
        logic [7:0] pat;
        pat = model_ctrl();
        e = '{ctrl: pat, err: (m_err != 0), stall: CW'(m_stall), flush: CW'(m_flush)};
        exp_q.push_back(e);
        @(negedge clk);
        got = '{ctrl: dut_ctrl(), err: mem_err, stall: stall_cnt, flush: flush_cnt};
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_ctrl"},  32'(got.ctrl),  32'(e.ctrl));
            check({tag, "_err"},   32'(got.err),   32'(e.err));
            check({tag, "_stall"}, 32'(got.stall), 32'(e.stall));
            check({tag, "_flush"}, 32'(got.flush), 32'(e.flush));
        end
        $display("[%0t] %s ctrl=%b err=%b stall=%0d flush=%0d", $time, tag,
                 got.ctrl, got.err, got.stall, got.flush);
        if (m_state != 2) begin
            if (!pat[7] && m_stall < 15) m_stall++;
            if (pat == P_BRAN && m_flush < 15) m_flush++;
        end
        case (m_state)
            0: begin
                m_wait = 0;
                if (dmem_req && !dmem_ready) m_state = 1;
            end
            1: begin
                if (dmem_ready) begin
                    m_state = 0; m_wait = 0;
                end else if (m_wait == TO) begin
                    m_state = 2; m_err = 1;
                end else begin
                    m_wait++;
                end
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle, checks the immediate response, releases after an edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_ctrl"},  32'(dut_ctrl()), 32'(P_RESET));
        check({tag, "_rst_err"},   32'(mem_err),    32'd0);
        check({tag, "_rst_stall"}, 32'(stall_cnt),  32'd0);
        check({tag, "_rst_flush"}, 32'(flush_cnt),  32'd0);
        $display("[%0t] %s reset ctrl=%b", $time, tag, dut_ctrl());
        m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
        set_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset("init");
        cycle("idle");

        // Load-use on rs1, then the bubble cycle
        set_lu_rs1(5'd5);
        cycle("lu_rs1");
        set_idle();
        cycle("lu_after");
        check("lu_stall_one", 32'(stall_cnt), 32'd1);

        // Load to x0 never stalls; rs2 match does; use flag gates the match
        set_lu_rs1(5'd0);
        cycle("lu_x0");
        set_idle();
        de_rd = 5'd9; de_regwrt = 1'b1; de_m2r = 1'b1; fd_rs2 = 5'd9; fd_use_rs2 = 1'b1;
        cycle("lu_rs2");
        fd_use_rs2 = 1'b0;
        cycle("lu_nouse");
        de_m2r = 1'b0; fd_use_rs2 = 1'b1;
        cycle("lu_notload");

        // Branch and load-use together: branch wins
        do_reset("br");
        set_lu_rs1(5'd5);
        branch_taken = 1'b1;
        cycle("br_lu");
        set_idle();
        cycle("br_after");
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Three wait cycles with a branch held pending
        do_reset("mw");
        branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mw_wait");
        dmem_ready = 1'b1;
        cycle("mw_ready");
        set_idle();
        cycle("mw_after");
        check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
        check("mw_flush_cnt", 32'(flush_cnt), 32'd1);

        // Timeout into FAULT after the 6th edge, sticky until reset
        do_reset("to");
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle("to_wait");
        check("to_mem_err", 32'(mem_err), 32'd1);
        check("to_ctrl", 32'(dut_ctrl()), 32'(P_FAULT));
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle("to_fault");
        do_reset("to_clr");
        cycle("to_clr_idle");
        check("to_err_clear", 32'(mem_err), 32'd0);

        // Ready in the last allowed cycle avoids the fault
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle("edge_wait");
        dmem_ready = 1'b1;
        cycle("edge_ready");
        set_idle();
        cycle("edge_after");
        check("edge_no_err", 32'(mem_err), 32'd0);

        // Statistics saturate at all-ones
        do_reset("sat");
        set_lu_rs1(5'd7);
        fd_rs1 = 5'd7;
        for (int i = 0; i < 20; i++) cycle("sat_lu");
        set_idle();
        cycle("sat_after");
        check("sat_stall", 32'(stall_cnt), 32'd15);

        // Reset while waiting forces the bubble pattern before any edge
        do_reset("ar");
        dmem_req = 1'b1; dmem_ready = 1'b0;
        cycle("ar_wait");
        cycle("ar_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ctrl", 32'(dut_ctrl()), 32'(P_RESET));
        check("ar_stall", 32'(stall_cnt), 32'd0);
        m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_idle();
        cycle("ar_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
